// File: rtl/snitch_icache_data_ctrl.sv
// Instruction-cache data array controller.
// Shares one array port between refill writes and lookup reads, with writes
// always taking priority. A granted read is issued to the hit way only. The
// SRAM returns data one cycle later and does not hold it, so it is captured
// in that cycle. The hit way's line then passes through a 2-entry response
// buffer to the consumer. A credit count bounds reads in flight plus buffered
// responses to two, so the buffer can never overflow and needs no full stall.

// Per-way read-data gate: passes a way's line only if that way was selected.
module snitch_icache_data_way_sel #(
    parameter int unsigned LINE_WIDTH = 128
) (
    input  logic                  sel,
    input  logic [LINE_WIDTH-1:0] rdata,
    output logic [LINE_WIDTH-1:0] masked
);

    // Zero the line unless this way was the captured hit way.
    always_comb begin
        masked = sel ? rdata : '0;
    end

endmodule

module snitch_icache_data_ctrl #(
    parameter int unsigned  WAY_COUNT   = 4,
    parameter int unsigned  LINE_COUNT  = 128,
    parameter int unsigned  LINE_WIDTH  = 128,
    parameter int unsigned  ID_WIDTH    = 4,
    localparam int unsigned COUNT_ALIGN = $clog2(LINE_COUNT)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,

    input  logic [COUNT_ALIGN-1:0]               lookup_addr_i,
    input  logic [WAY_COUNT-1:0]                 lookup_way_i,
    input  logic [ID_WIDTH-1:0]                  lookup_id_i,
    input  logic                                 lookup_valid_i,
    output logic                                 lookup_ready_o,

    input  logic [COUNT_ALIGN-1:0]               write_addr_i,
    input  logic [WAY_COUNT-1:0]                 write_way_i,
    input  logic [LINE_WIDTH-1:0]                write_data_i,
    input  logic                                 write_valid_i,
    output logic                                 write_ready_o,

    output logic [LINE_WIDTH-1:0]                rsp_data_o,
    output logic [ID_WIDTH-1:0]                  rsp_id_o,
    output logic                                 rsp_valid_o,
    input  logic                                 rsp_ready_i,

    output logic [WAY_COUNT-1:0]                 ram_enable_o,
    output logic                                 ram_write_o,
    output logic [COUNT_ALIGN-1:0]               ram_addr_o,
    output logic [LINE_WIDTH-1:0]                ram_wdata_o,
    input  logic [WAY_COUNT-1:0][LINE_WIDTH-1:0] ram_rdata_i
);

    // ------------------------------------------------------------------
    // Handshake and credit accounting
    // ------------------------------------------------------------------
    logic                  lookup_fire;
    logic                  pop;
    logic                  push;
    logic [2:0]            credit;

    // Read issued last cycle; its data is on ram_rdata_i this cycle.
    logic                  inflight_q;
    logic [WAY_COUNT-1:0]  way_q;
    logic [ID_WIDTH-1:0]   id_q;

    // Two-entry response buffer: slot 0 is the head driven onto rsp_*.
    logic [1:0]            occ_q;
    logic [LINE_WIDTH-1:0] head_data_q;
    logic [ID_WIDTH-1:0]   head_id_q;
    logic [LINE_WIDTH-1:0] tail_data_q;
    logic [ID_WIDTH-1:0]   tail_id_q;

    // Line of the captured hit way (all-zero for an empty way mask).
    logic [WAY_COUNT-1:0][LINE_WIDTH-1:0] masked;
    logic [LINE_WIDTH-1:0]                sel_data;

    assign write_ready_o = 1'b1;
    assign rsp_valid_o   = (occ_q != 2'd0);
    assign rsp_data_o    = head_data_q;
    assign rsp_id_o      = head_id_q;

    assign pop  = rsp_valid_o & rsp_ready_i;
    assign push = inflight_q;

    // Buffered + in-flight, less the response that leaves this cycle. A pop
    // needs occ_q >= 1, so the subtraction never wraps.
    assign credit = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

    // A new read needs a guaranteed buffer slot and a free array port.
    assign lookup_ready_o = !write_valid_i && (credit < 3'd2);
    assign lookup_fire    = lookup_valid_i & lookup_ready_o;

    // ------------------------------------------------------------------
    // Array port: the SRAM registers these, so they stay combinational
    // ------------------------------------------------------------------
    // Refill has priority. A lookup is granted only in a cycle with no write.
    always_comb begin
        ram_enable_o = '0;
        ram_write_o  = 1'b0;
        ram_addr_o   = lookup_addr_i;
        ram_wdata_o  = write_data_i;
        if (write_valid_i) begin
            ram_enable_o = write_way_i;
            ram_write_o  = 1'b1;
            ram_addr_o   = write_addr_i;
        end else if (lookup_fire) begin
            ram_enable_o = lookup_way_i;
        end
    end

    // ------------------------------------------------------------------
    // Issue stage: remember which way and ID the outstanding read belongs to
    // ------------------------------------------------------------------
    // The in-flight flag follows the fire strobe. Way and ID are kept only on fire.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q <= 1'b0;
            way_q      <= '0;
            id_q       <= '0;
        end else begin
            inflight_q <= lookup_fire;
            if (lookup_fire) begin
                way_q <= lookup_way_i;
                id_q  <= lookup_id_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Capture stage: gate each way, then OR the ways together
    // ------------------------------------------------------------------
    for (genvar w = 0; w < WAY_COUNT; w++) begin : g_way
        snitch_icache_data_way_sel #(
            .LINE_WIDTH (LINE_WIDTH)
        ) i_way_sel (
            .sel    (way_q[w]),
            .rdata  (ram_rdata_i[w]),
            .masked (masked[w])
        );
    end

    // OR-reduce the gated ways. At most one way is non-zero for a onehot0 mask.
    always_comb begin
        sel_data = '0;
        for (int w = 0; w < WAY_COUNT; w++) begin
            sel_data = sel_data | masked[w];
        end
    end

    // ------------------------------------------------------------------
    // Response buffer
    // ------------------------------------------------------------------
    // Push the captured line and pop on the consumer handshake. Credits rule
    // out a push into a full buffer without a simultaneous pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q       <= 2'd0;
            head_data_q <= '0;
            head_id_q   <= '0;
            tail_data_q <= '0;
            tail_id_q   <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        head_data_q <= sel_data;
                        head_id_q   <= id_q;
                    end else begin
                        tail_data_q <= sel_data;
                        tail_id_q   <= id_q;
                    end
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    head_data_q <= tail_data_q;
                    head_id_q   <= tail_id_q;
                    occ_q       <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        head_data_q <= sel_data;
                        head_id_q   <= id_q;
                    end else begin
                        head_data_q <= tail_data_q;
                        head_id_q   <= tail_id_q;
                        tail_data_q <= sel_data;
                        tail_id_q   <= id_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snitch_icache_data_ctrl.sv
// Bench for snitch_icache_data_ctrl: directed scenarios plus a per-cycle
// scoreboard. The scoreboard keeps the accepted lookups in a queue. It knows
// each response is due two cycles after acceptance and must leave in order.
module tb_snitch_icache_data_ctrl;
    localparam int WAYS  = 4;
    localparam int LINES = 128;
    localparam int LW    = 128;
    localparam int AW    = 7;
    localparam int IW    = 4;

    logic                       clk = 1'b0;
    logic                       rst_ni;
    logic [AW-1:0]              lookup_addr;
    logic [WAYS-1:0]            lookup_way;
    logic [IW-1:0]              lookup_id;
    logic                       lookup_valid;
    logic                       lookup_ready;
    logic [AW-1:0]              write_addr;
    logic [WAYS-1:0]            write_way;
    logic [LW-1:0]              write_data;
    logic                       write_valid;
    logic                       write_ready;
    logic [LW-1:0]              rsp_data;
    logic [IW-1:0]              rsp_id;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [WAYS-1:0]            ram_enable;
    logic                       ram_write;
    logic [AW-1:0]              ram_addr;
    logic [LW-1:0]              ram_wdata;
    logic [WAYS-1:0][LW-1:0]    ram_rdata;

    always #5 clk = ~clk;

    snitch_icache_data_ctrl dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .lookup_addr_i  (lookup_addr),
        .lookup_way_i   (lookup_way),
        .lookup_id_i    (lookup_id),
        .lookup_valid_i (lookup_valid),
        .lookup_ready_o (lookup_ready),
        .write_addr_i   (write_addr),
        .write_way_i    (write_way),
        .write_data_i   (write_data),
        .write_valid_i  (write_valid),
        .write_ready_o  (write_ready),
        .rsp_data_o     (rsp_data),
        .rsp_id_o       (rsp_id),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .ram_enable_o   (ram_enable),
        .ram_write_o    (ram_write),
        .ram_addr_o     (ram_addr),
        .ram_wdata_o    (ram_wdata),
        .ram_rdata_i    (ram_rdata)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [LW-1:0] data;
        logic [IW-1:0] id;
        int            acc;
    } exp_t;

    exp_t          exp_q[$];
    int            log_cyc[$];
    logic [IW-1:0] log_id[$];

    logic [LW-1:0] mem  [WAYS][LINES];
    bit            seen [WAYS][LINES];

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Power-up content of the array, distinct for every way and line.
    function automatic logic [LW-1:0] init_val(int w, int l);
        return {32'h1CE0_0000 + 32'(w), 32'(l), 32'hC0DE_0000 + 32'(l * 7 + w), 32'h5A5A_0000 | 32'(w)};
    endfunction

    function automatic logic [LW-1:0] rd(int w, int l);
        return seen[w][l] ? mem[w][l] : init_val(w, l);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: one-cycle read latency, poison on the output otherwise.
    always @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (ram_enable[w] && ram_write) begin
                mem[w][ram_addr]  <= ram_wdata;
                seen[w][ram_addr] <= 1'b1;
            end
            if (ram_enable[w] && !ram_write) ram_rdata[w] <= rd(w, int'(ram_addr));
            else                             ram_rdata[w] <= {4{32'hDEAD_BEE0 | 32'(w)}};
        end
    end

    // Scoreboard and protocol checks, sampled on the falling edge.
    logic          hold_q = 1'b0;
    logic [AW-1:0] p_addr;
    logic [WAYS-1:0] p_way;
    logic [IW-1:0] p_id;

    always @(negedge clk) begin
        logic [WAYS-1:0] e_en;
        logic            e_rdy;
        logic            e_vld;
        logic            popn;
        logic [LW-1:0]   e_data;
        int              widx;
        assert ($onehot0(write_way));
        assert ($onehot0(lookup_way));
        if (!rst_ni) begin
            chk("rst_rsp_valid", rsp_valid, 1'b0);
            exp_q.delete();
            hold_q = 1'b0;
        end else if (hold_q) begin
            assert (lookup_valid && lookup_addr == p_addr && lookup_way == p_way && lookup_id == p_id)
                else $error("lookup inputs changed while stalled");
        end
        popn  = rst_ni && rsp_valid && rsp_ready;
        e_rdy = !write_valid && (exp_q.size() - int'(popn)) < 2;
        chk("lookup_ready", lookup_ready, e_rdy);
        chk("write_ready", write_ready, 1'b1);
        e_en = write_valid ? write_way : ((lookup_valid && e_rdy) ? lookup_way : '0);
        chk("ram_enable", ram_enable, e_en);
        chk("ram_write", ram_write, write_valid);
        chk("ram_addr", ram_addr, write_valid ? write_addr : lookup_addr);
        if (write_valid) chk("ram_wdata", ram_wdata, write_data);
        if (rst_ni) begin
            e_vld = exp_q.size() > 0 && exp_q[0].acc + 2 <= cyc;
            chk("rsp_valid", rsp_valid, e_vld);
            if (rsp_valid && exp_q.size() > 0) begin
                chk("rsp_data", rsp_data, exp_q[0].data);
                chk("rsp_id", rsp_id, exp_q[0].id);
            end
            if (popn && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                log_cyc.push_back(cyc);
                log_id.push_back(rsp_id);
            end
            if (lookup_valid && lookup_ready) begin
                widx = 0;
                for (int w = 0; w < WAYS; w++) if (lookup_way[w]) widx = w;
                e_data = (lookup_way == '0) ? '0 : rd(widx, int'(lookup_addr));
                exp_q.push_back('{data: e_data, id: lookup_id, acc: cyc});
            end
            hold_q = lookup_valid && !lookup_ready;
            p_addr = lookup_addr;
            p_way  = lookup_way;
            p_id   = lookup_id;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        lookup_valid = 1'b0; lookup_addr = '0; lookup_way = '0; lookup_id = '0;
        write_valid  = 1'b0; write_addr  = '0; write_way  = '0; write_data = '0;
    endtask

    // Wait for the next response handshake and check it against literals.
    task automatic wait_rsp(input string nm, input int acc, input logic [LW-1:0] d, input logic [IW-1:0] id);
        bit got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                got = 1'b1;
                chk({nm, "_latency"}, cyc, acc + 2);
                chk({nm, "_data"}, rsp_data, d);
                chk({nm, "_id"}, rsp_id, id);
            end
        end
        if (!got) chk({nm, "_timeout"}, 1'b0, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int            acc;
        int            nacc;
        logic [IW-1:0] nid;
        logic [LW-1:0] x_data;

        rst_ni    = 1'b0;
        rsp_ready = 1'b1;
        idle();

        // Reset state.
        repeat (2) @(negedge clk);
        chk("reset_valid", rsp_valid, 1'b0);
        chk("reset_data", rsp_data, '0);
        chk("reset_id", rsp_id, '0);
        chk("reset_enable", ram_enable, 4'b0000);
        chk("reset_write", ram_write, 1'b0);
        step();
        rst_ni = 1'b1;
        step();

        // Refill a line, then read it back.
        write_valid = 1'b1; write_addr = 7'd5; write_way = 4'b0100;
        write_data  = {16{8'hA5}};
        @(negedge clk);
        chk("wr_enable", ram_enable, 4'b0100);
        chk("wr_write", ram_write, 1'b1);
        step();
        idle();
        lookup_valid = 1'b1; lookup_addr = 7'd5; lookup_way = 4'b0100; lookup_id = 4'd3;
        @(negedge clk);
        chk("rd_enable", ram_enable, 4'b0100);
        chk("rd_ready", lookup_ready, 1'b1);
        acc = cyc;
        step();
        idle();
        wait_rsp("raw", acc, {16{8'hA5}}, 4'd3);

        // Streaming with the consumer always ready.
        step();
        log_cyc.delete(); log_id.delete();
        for (int i = 0; i < 8; i++) begin
            lookup_valid = 1'b1; lookup_addr = 7'(i + 16);
            lookup_way = 4'(1 << (i % 4)); lookup_id = 4'(i);
            @(negedge clk);
            chk("stream_ready", lookup_ready, 1'b1);
            if (i == 0) acc = cyc;
            step();
        end
        idle();
        repeat (4) step();
        chk("stream_count", 32'(log_id.size()), 32'd8);
        for (int i = 0; i < 8 && i < log_id.size(); i++) begin
            chk("stream_id", log_id[i], 4'(i));
            chk("stream_cycle", log_cyc[i], acc + 2 + i);
        end

        // Backpressure: only two lookups fit while the consumer stalls.
        rsp_ready = 1'b0;
        log_cyc.delete(); log_id.delete();
        nid = 4'hA; nacc = 0;
        lookup_valid = 1'b1; lookup_addr = 7'd40; lookup_way = 4'b0010; lookup_id = nid;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (lookup_ready) begin nacc++; nid = nid + 4'd1; end
            step();
            lookup_id = nid;
        end
        chk("bp_accepted", nacc, 2);
        @(negedge clk);
        chk("bp_ready", lookup_ready, 1'b0);
        chk("bp_enable", ram_enable, 4'b0000);
        chk("bp_valid", rsp_valid, 1'b1);
        step();
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (lookup_ready) begin
                step();
                break;
            end
            step();
        end
        idle();
        repeat (6) step();
        chk("bp_count", 32'(log_id.size()), 32'd3);
        if (log_id.size() == 3) begin
            chk("bp_id0", log_id[0], 4'hA);
            chk("bp_id1", log_id[1], 4'hB);
            chk("bp_id2", log_id[2], 4'hC);
        end

        // Same-cycle write and lookup: the write wins, the lookup follows.
        x_data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        write_valid = 1'b1; write_addr = 7'd7; write_way = 4'b0001; write_data = x_data;
        lookup_valid = 1'b1; lookup_addr = 7'd9; lookup_way = 4'b1000; lookup_id = 4'd5;
        @(negedge clk);
        chk("col_write", ram_write, 1'b1);
        chk("col_enable", ram_enable, 4'b0001);
        chk("col_addr", ram_addr, 7'd7);
        chk("col_ready", lookup_ready, 1'b0);
        step();
        write_valid = 1'b0;
        @(negedge clk);
        chk("col_issue_enable", ram_enable, 4'b1000);
        chk("col_issue_write", ram_write, 1'b0);
        chk("col_issue_ready", lookup_ready, 1'b1);
        acc = cyc;
        step();
        idle();
        wait_rsp("col", acc, init_val(3, 9), 4'd5);

        // Refilled line at addr 7 way 0 reads back.
        step();
        lookup_valid = 1'b1; lookup_addr = 7'd7; lookup_way = 4'b0001; lookup_id = 4'd6;
        @(negedge clk);
        acc = cyc;
        step();
        idle();
        wait_rsp("col_raw", acc, x_data, 4'd6);

        // Zero way mask: no SRAM access, zero data, ID still returned.
        step();
        lookup_valid = 1'b1; lookup_addr = 7'd3; lookup_way = 4'b0000; lookup_id = 4'd9;
        @(negedge clk);
        chk("zero_enable", ram_enable, 4'b0000);
        chk("zero_ready", lookup_ready, 1'b1);
        acc = cyc;
        step();
        idle();
        wait_rsp("zero", acc, '0, 4'd9);

        // Reset with two responses outstanding discards them.
        step();
        rsp_ready = 1'b0;
        lookup_valid = 1'b1; lookup_addr = 7'd1; lookup_way = 4'b0001; lookup_id = 4'd1;
        step();
        lookup_addr = 7'd2; lookup_way = 4'b0010; lookup_id = 4'd2;
        step();
        idle();
        repeat (2) step();
        @(negedge clk);
        chk("prereset_valid", rsp_valid, 1'b1);
        step();
        log_cyc.delete(); log_id.delete();
        rst_ni = 1'b0;
        #1;
        chk("async_reset_valid", rsp_valid, 1'b0);
        step();
        step();
        rst_ni = 1'b1;
        rsp_ready = 1'b1;
        repeat (6) step();
        chk("postreset_count", 32'(log_id.size()), 32'd0);
        @(negedge clk);
        chk("postreset_ready", lookup_ready, 1'b1);
        chk("postreset_valid", rsp_valid, 1'b0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snitch_icache_data_ctrl.md
Name: snitch_icache_data_ctrl

Overview:
Initiator-side controller for the instruction-cache data array (per-way line SRAMs with 1-cycle read latency, no read-data hold).
- Arbitrates refill writes and lookup reads onto the single shared array port.
- Drives a per-way enable so only the hit way is activated.
- Captures read data in the cycle after issue, selects the hit way and returns it through a 2-entry response buffer with valid/ready backpressure.

Parameters:
WAY_COUNT, 4, number of ways (one SRAM bank per way)
LINE_COUNT, 128, lines per way
LINE_WIDTH, 128, bits per cache line
COUNT_ALIGN, $clog2(LINE_COUNT), line-index width (derived, not overridden)
ID_WIDTH, 4, lookup transaction ID width

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
lookup_addr_i  in  COUNT_ALIGN  line index to read
lookup_way_i  in  WAY_COUNT  hit way, one-hot or zero
lookup_id_i  in  ID_WIDTH  ID echoed on response
lookup_valid_i  in  1  lookup request valid
lookup_ready_o  out  1  lookup accepted when valid&ready
write_addr_i  in  COUNT_ALIGN  refill line index
write_way_i  in  WAY_COUNT  refill way, one-hot or zero
write_data_i  in  LINE_WIDTH  refill line data
write_valid_i  in  1  refill write valid
write_ready_o  out  1  refill accepted, tied 1
rsp_data_o  out  LINE_WIDTH  selected line data
rsp_id_o  out  ID_WIDTH  echoed lookup ID
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumer ready
ram_enable_o  out  WAY_COUNT  per-way SRAM request
ram_write_o  out  1  SRAM write enable
ram_addr_o  out  COUNT_ALIGN  SRAM line index
ram_wdata_o  out  LINE_WIDTH  SRAM write data, all byte enables implied
ram_rdata_i  in  WAY_COUNT x LINE_WIDTH  per-way read data, valid only the cycle after a read request

Behaviour:
- Reset: response buffer empty, in-flight flag 0, rsp_valid_o=0, rsp_data_o=0, rsp_id_o=0. With inputs idle, ram_enable_o=0 and ram_write_o=0.
- Array outputs are combinational (the SRAM registers them):
  - write_valid_i=1: ram_write_o=1, ram_enable_o=write_way_i, ram_addr_o=write_addr_i, ram_wdata_o=write_data_i.
  - else, on lookup fire: ram_write_o=0, ram_enable_o=lookup_way_i, ram_addr_o=lookup_addr_i.
  - else: ram_enable_o=0; ram_addr_o=lookup_addr_i; ram_wdata_o=write_data_i.
- Priority: writes always win; write_ready_o=1; a refill is never stalled.
- Credit rule: count = buffer occupancy + in-flight − (rsp_valid_o & rsp_ready_i). lookup_ready_o = !write_valid_i && count < 2.
- Issue, cycle t: register in-flight=1, plus the lookup's way mask and ID.
- Capture, cycle t+1: push {OR over ways of (ram_rdata_i[w] masked by captured way bit), ID} into the buffer. In-flight clears unless a new lookup issues that cycle.
- Latency: accept at t gives rsp_valid_o at t+2 when the buffer was empty. Sustained throughput is 1 response per cycle while rsp_ready_i=1.
- Ordering: responses return in strict acceptance order. Writes never create responses.
- Zero way mask (lookup_way_i=0): no SRAM enable; the response still returns with rsp_data_o=0 and the ID.
- Buffer: 2-entry FIFO, head on rsp_*. Push and pop in the same cycle are allowed at any occupancy ≤2. Credits make overflow impossible.
- Read-after-write: a write at t followed by a lookup of the same line at t+1 or later returns the new data. Same-cycle write and lookup resolve as write first, lookup deferred.
- rsp_data_o/rsp_id_o hold stable while rsp_valid_o=1 and rsp_ready_i=0.
- Async reset mid-operation: in-flight read and buffered responses are discarded, with no response afterwards. ram_enable_o returns to 0 as soon as the request inputs drop.
- Bench assertions: write_way_i and lookup_way_i onehot0; lookup inputs stable while lookup_valid_i & !lookup_ready_o.

Test Plan:
- Reset: 2 lookups outstanding, rst_ni pulsed low -> rsp_valid_o=0 immediately; no response after release; lookup_ready_o=1 with write_valid_i=0.
- Write then read: write addr 5, way 4'b0100, data 128'hA5A5..A5, then lookup addr 5, way 4'b0100, ID 3 -> ram_enable_o=4'b0100 on both; rsp at accept+2 with data A5..A5, ID 3.
- Streaming: 8 lookups, IDs 0..7, rsp_ready_i=1 -> lookup_ready_o constantly 1; responses on 8 consecutive cycles starting accept+2, IDs 0..7 in order.
- Backpressure: rsp_ready_i=0, lookup_valid_i held -> exactly 2 accepted, then lookup_ready_o=0 and ram_enable_o=0. Raising rsp_ready_i drains the IDs in order, with no loss or duplicate.
- Collision: write and lookup valid in the same cycle -> ram_write_o=1, ram_enable_o=write way, lookup_ready_o=0; lookup issues the next cycle.
- Zero way: lookup with way 0, ID 9 -> ram_enable_o=0; response data 0, ID 9 at accept+2.
